// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter feeding a shared UART TX stream
//
// Purpose: grants one of NREQ requester streams at a time onto a single
// stream toward the UART TX FIFO. The grant is held for a whole packet, or
// until an optional per-grant beat limit is reached. Every release is followed
// by one idle (bubble) cycle before the next arbitration.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   en_mask      per-requester arbitration enable (sampled only while idle)
//   burst_limit  max beats per grant, 0 = unlimited (captured on grant entry)
//   s_tdata      requester data, requester i at [i*DW +: DW]
//   s_tvalid     per-requester valid
//   s_tlast      per-requester end-of-packet
//   s_tready     per-requester ready (only the granted requester sees m_tready)
//   m_tdata      shared stream data
//   m_tvalid     shared stream valid
//   m_tlast      shared stream end-of-packet (passed through unmodified)
//   m_tready     ready from the UART TX FIFO
//   grant_idx    current or last granted requester
//   busy         high while a grant is held

module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int BW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    en_mask,
  input  logic [BW-1:0]      burst_limit,
  input  logic [NREQ*DW-1:0] s_tdata,
  input  logic [NREQ-1:0]    s_tvalid,
  input  logic [NREQ-1:0]    s_tlast,
  output logic [NREQ-1:0]    s_tready,
  output logic [DW-1:0]      m_tdata,
  output logic               m_tvalid,
  output logic               m_tlast,
  input  logic               m_tready,
  output logic [2:0]         grant_idx,
  output logic               busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    grant_idx_q, grant_idx_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] limit_q, limit_d;

  // Round-robin pick: the first candidate at offsets 1..NREQ from the last
  // grant. Offset NREQ wraps back to the last winner itself, so a lone
  // requester can be granted again.
  logic [NREQ-1:0] cand;
  logic            pick_found;
  logic [2:0]      pick_idx;
  int              tgt;

  always_comb begin
    cand       = s_tvalid & en_mask;
    pick_found = 1'b0;
    pick_idx   = grant_idx_q;
    tgt        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      tgt = int'(grant_idx_q) + k;
      if (tgt >= NREQ) begin
        tgt = tgt - NREQ;
      end
      for (int j = 0; j < NREQ; j++) begin
        if (!pick_found && cand[j] && (tgt == j)) begin
          pick_found = 1'b1;
          pick_idx   = 3'(j);
        end
      end
    end
  end

  // Signals of the currently granted requester.
  logic          g_valid;
  logic          g_last;
  logic [DW-1:0] g_data;

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_idx_q == 3'(j)) begin
        g_valid = s_tvalid[j];
        g_last  = s_tlast[j];
        g_data  = s_tdata[j*DW +: DW];
      end
    end
  end

  logic          xfer;
  logic [BW-1:0] cnt_inc;
  logic          limit_hit;
  logic          release_grant;

  assign xfer          = (state_q == ST_GRANT) && g_valid && m_tready;
  // Saturating increment keeps a long unlimited packet from wrapping the count.
  assign cnt_inc       = (&cnt_q) ? cnt_q : cnt_q + BW'(1);
  assign limit_hit     = (limit_q != '0) && (cnt_inc == limit_q);
  // tlast and limit reaching together still produce one release.
  assign release_grant = xfer && (g_last || limit_hit);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= 3'(NREQ - 1);
      cnt_q       <= '0;
      limit_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      cnt_q       <= cnt_d;
      limit_q     <= limit_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    cnt_d       = cnt_q;
    limit_d     = limit_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d     = ST_GRANT;
          grant_idx_d = pick_idx;
          cnt_d       = '0;
          limit_d     = burst_limit;
        end
      end
      ST_GRANT: begin
        if (xfer) begin
          cnt_d = cnt_inc;
        end
        if (release_grant) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: zero-latency pass-through of the granted requester.
  always_comb begin
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    busy     = 1'b0;
    if (state_q == ST_GRANT) begin
      busy     = 1'b1;
      m_tvalid = g_valid;
      m_tdata  = g_data;
      m_tlast  = g_last;
      for (int j = 0; j < NREQ; j++) begin
        s_tready[j] = (grant_idx_q == 3'(j)) && m_tready;
      end
    end
  end

  assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int BW   = 8;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    en_mask;
  logic [BW-1:0]      burst_limit;
  logic [NREQ*DW-1:0] s_tdata;
  logic [NREQ-1:0]    s_tvalid;
  logic [NREQ-1:0]    s_tlast;
  logic [NREQ-1:0]    s_tready;
  logic [DW-1:0]      m_tdata;
  logic               m_tvalid;
  logic               m_tlast;
  logic               m_tready;
  logic [2:0]         grant_idx;
  logic               busy;

  uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .BW(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_mask    (en_mask),
    .burst_limit(burst_limit),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .grant_idx  (grant_idx),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t sb_q[$];
  int    g_log[$];
  int    b_log[$];
  int    s_log[$];
  int    e_log[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0]      dd [NREQ][64];
  logic            dl [NREQ][64];
  int              wr_p [NREQ];
  int              rd_p [NREQ];
  int              seq  [NREQ];
  logic [NREQ-1:0] gate;
  logic [NREQ-1:0] hs;
  logic [BW-1:0]   cfg_limit;
  bit              toggle;
  bit              perturb;
  bit              mon_en;
  bit              prev_busy;

  task automatic load_pkt(input int i, input int len);
    beat_t b;
    if (rd_p[i] == wr_p[i]) begin
      rd_p[i] = 0;
      wr_p[i] = 0;
    end
    for (int k = 0; k < len; k++) begin
      b.idx  = i;
      b.data = {2'(i), 6'(seq[i])};
      b.last = (k == len - 1);
      dd[i][wr_p[i]] = b.data;
      dl[i][wr_p[i]] = b.last;
      wr_p[i]++;
      seq[i]++;
      sb_q.push_back(b);
    end
  endtask

  task automatic flush_req(input int i);
    rd_p[i] = wr_p[i];
    for (int k = sb_q.size() - 1; k >= 0; k--) begin
      if (sb_q[k].idx == i) sb_q.delete(k);
    end
  endtask

  task automatic clear_logs();
    g_log.delete();
    b_log.delete();
    s_log.delete();
    e_log.delete();
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      if (rd_p[i] < wr_p[i]) begin
        s_tvalid[i]          = gate[i];
        s_tdata[i*DW +: DW]  = dd[i][rd_p[i]];
        s_tlast[i]           = dl[i][rd_p[i]];
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tdata[i*DW +: DW]  = '0;
        s_tlast[i]           = 1'b0;
      end
    end
    m_tready    = toggle ? ((cyc % 2) == 0) : 1'b1;
    burst_limit = (perturb && busy === 1'b1) ? BW'(1) : cfg_limit;
  endtask

  task automatic monitor();
    int              found;
    logic [NREQ-1:0] exp_rdy;
    hs = s_tvalid & s_tready;
    if (!mon_en) return;
    if (busy === 1'b1 && !prev_busy) begin
      g_log.push_back(int'(grant_idx));
      b_log.push_back(0);
      s_log.push_back(cyc);
      e_log.push_back(cyc);
    end
    n_tests++;
    if (busy !== 1'b1) begin
      if (s_tready !== '0 || m_tvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_outputs cyc %0d: s_tready=%b m_tvalid=%b, required 0000/0", cyc, s_tready, m_tvalid);
      end
    end else begin
      exp_rdy = m_tready ? (NREQ'(1) << grant_idx) : '0;
      if (s_tready !== exp_rdy) begin
        n_fail++;
        $display("FAIL grant_ready cyc %0d: s_tready=%b, required %b", cyc, s_tready, exp_rdy);
      end
    end
    if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
      if (b_log.size() > 0) begin
        b_log[b_log.size()-1] = b_log[b_log.size()-1] + 1;
        e_log[e_log.size()-1] = cyc;
      end
      found = -1;
      for (int k = 0; k < sb_q.size(); k++) begin
        if (found < 0 && sb_q[k].idx == int'(grant_idx)) found = k;
      end
      n_tests++;
      if (found < 0) begin
        n_fail++;
        $display("FAIL sb_unexpected cyc %0d: beat %h from requester %0d, required none", cyc, m_tdata, grant_idx);
      end else begin
        if (m_tdata !== sb_q[found].data || m_tlast !== sb_q[found].last) begin
          n_fail++;
          $display("FAIL sb_beat cyc %0d: data=%h last=%b, required data=%h last=%b", cyc, m_tdata, m_tlast, sb_q[found].data, sb_q[found].last);
        end
        sb_q.delete(found);
      end
    end
    prev_busy = (busy === 1'b1);
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i]) rd_p[i]++;
    end
    apply();
  endtask

  task automatic run_drain(input int budget, input string name);
    int n = 0;
    while (!(sb_q.size() == 0 && busy === 1'b0) && n < budget) begin
      tick();
      n++;
    end
    if (!(sb_q.size() == 0 && busy === 1'b0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: %0d beats outstanding, required 0", name, sb_q.size());
    end
  endtask

  task automatic run_grants(input int ng, input int budget, input string name);
    int n = 0;
    while (!(g_log.size() >= ng && busy === 1'b0) && n < budget) begin
      tick();
      n++;
    end
    if (!(g_log.size() >= ng && busy === 1'b0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: %0d grants seen, required %0d", name, g_log.size(), ng);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) flush_req(i);
    apply();
    tick();
    tick();
    rst       = 1'b1;
    en_mask   = 4'hF;
    cfg_limit = '0;
    toggle    = 1'b0;
    perturb   = 1'b0;
    gate      = '1;
    apply();
    clear_logs();
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    en_mask = 4'hF;
    gate    = '1;
    load_pkt(1, 2);
    apply();
    tick();
    mon_en = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b m_tvalid=%b s_tready=%b, required 0/0/0000", busy, m_tvalid, s_tready);
    end
    n_tests++;
    if (grant_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL reset_grant_idx: got %0d, expected 3", grant_idx);
    end
    rst     = 1'b1;
    en_mask = 4'h0;
    apply();
    tick();
    tick();
    n_tests++;
    if (busy !== 1'b0 || grant_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL masked_idle: busy=%b grant_idx=%0d, required 0/3", busy, grant_idx);
    end
    en_mask = 4'hF;
    apply();
    run_drain(50, "reset_drain");
    n_tests++;
    if (g_log.size() != 1 || g_log[0] != 1) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %0d grants (first %0d), expected 1 grant to 1", g_log.size(), (g_log.size() > 0) ? g_log[0] : -1);
    end
  endtask

  task automatic test_round_robin();
    int eg[5] = '{0, 1, 2, 3, 0};
    do_reset();
    load_pkt(0, 3);
    load_pkt(0, 3);
    load_pkt(1, 3);
    load_pkt(2, 3);
    load_pkt(3, 3);
    apply();
    run_drain(200, "rr_drain");
    n_tests++;
    if (g_log.size() != 5) begin
      n_fail++;
      $display("FAIL rr_grant_count: got %0d, expected 5", g_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_tests++;
        if (g_log[k] != eg[k] || b_log[k] != 3 || e_log[k] - s_log[k] != 2) begin
          n_fail++;
          $display("FAIL rr_grant%0d: idx=%0d beats=%0d span=%0d, expected idx=%0d beats=3 span=2", k, g_log[k], b_log[k], e_log[k] - s_log[k], eg[k]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (s_log[k+1] - e_log[k] != 2) begin
          n_fail++;
          $display("FAIL rr_bubble%0d: gap=%0d, expected 2", k, s_log[k+1] - e_log[k]);
        end
      end
    end
  endtask

  task automatic test_burst_limit();
    int eg[4] = '{1, 2, 1, 1};
    int eb[4] = '{4, 3, 4, 2};
    do_reset();
    cfg_limit = 8'd4;
    perturb   = 1'b1;
    load_pkt(1, 10);
    load_pkt(2, 3);
    apply();
    run_drain(200, "burst_drain");
    n_tests++;
    if (g_log.size() != 4) begin
      n_fail++;
      $display("FAIL burst_grant_count: got %0d, expected 4", g_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (g_log[k] != eg[k] || b_log[k] != eb[k]) begin
          n_fail++;
          $display("FAIL burst_grant%0d: idx=%0d beats=%0d, expected idx=%0d beats=%0d", k, g_log[k], b_log[k], eg[k], eb[k]);
        end
      end
    end
  endtask

  task automatic test_ready_toggle();
    do_reset();
    cfg_limit = 8'd4;
    toggle    = 1'b1;
    load_pkt(3, 6);
    apply();
    tick();
    tick();
    tick();
    gate[3] = 1'b0;
    apply();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (busy !== 1'b1 || m_tvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_invalid%0d: busy=%b m_tvalid=%b, required 1/0", k, busy, m_tvalid);
      end
    end
    gate[3] = 1'b1;
    apply();
    run_drain(200, "toggle_drain");
    n_tests++;
    if (g_log.size() != 2 || g_log[0] != 3 || g_log[1] != 3 || b_log[0] != 4 || b_log[1] != 2) begin
      n_fail++;
      $display("FAIL toggle_grants: %0d grants, beats %0d/%0d, expected 2 grants to 3 with beats 4/2", g_log.size(), (b_log.size() > 0) ? b_log[0] : -1, (b_log.size() > 1) ? b_log[1] : -1);
    end
  endtask

  task automatic test_en_mask();
    int eg[9] = '{0, 2, 0, 2, 0, 1, 3, 1, 3};
    int eb[9] = '{2, 2, 2, 2, 4, 2, 2, 2, 2};
    do_reset();
    en_mask = 4'b0101;
    for (int i = 0; i < NREQ; i++) begin
      load_pkt(i, 2);
      load_pkt(i, 2);
    end
    apply();
    run_grants(4, 200, "mask_alt");
    load_pkt(0, 4);
    apply();
    tick();
    tick();
    en_mask = 4'b0100;
    apply();
    run_grants(5, 100, "mask_clear");
    en_mask = 4'hF;
    apply();
    run_drain(200, "mask_drain");
    n_tests++;
    if (g_log.size() != 9) begin
      n_fail++;
      $display("FAIL mask_grant_count: got %0d, expected 9", g_log.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        n_tests++;
        if (g_log[k] != eg[k] || b_log[k] != eb[k]) begin
          n_fail++;
          $display("FAIL mask_grant%0d: idx=%0d beats=%0d, expected idx=%0d beats=%0d", k, g_log[k], b_log[k], eg[k], eb[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    load_pkt(2, 5);
    apply();
    tick();
    tick();
    rst = 1'b0;
    apply();
    tick();
    rst = 1'b1;
    apply();
    n_tests++;
    if (busy !== 1'b0 || s_tready !== '0 || m_tvalid !== 1'b0 || grant_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b s_tready=%b m_tvalid=%b grant_idx=%0d, required 0/0000/0/3", busy, s_tready, m_tvalid, grant_idx);
    end
    flush_req(2);
    clear_logs();
    load_pkt(1, 2);
    load_pkt(3, 2);
    apply();
    run_drain(100, "abort_drain");
    n_tests++;
    if (g_log.size() != 2 || g_log[0] != 1 || g_log[1] != 3) begin
      n_fail++;
      $display("FAIL abort_regrant: %0d grants (first %0d), expected grants 1 then 3", g_log.size(), (g_log.size() > 0) ? g_log[0] : -1);
    end
  endtask

  task automatic test_limit_one();
    int eg[3] = '{0, 1, 0};
    do_reset();
    cfg_limit = 8'd1;
    load_pkt(0, 1);
    load_pkt(0, 1);
    load_pkt(1, 1);
    apply();
    run_drain(100, "one_drain");
    n_tests++;
    if (g_log.size() != 3) begin
      n_fail++;
      $display("FAIL one_grant_count: got %0d, expected 3", g_log.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (g_log[k] != eg[k] || b_log[k] != 1 || (k < 2 && s_log[k+1] - e_log[k] != 2)) begin
          n_fail++;
          $display("FAIL one_grant%0d: idx=%0d beats=%0d, expected idx=%0d beats=1 with one bubble", k, g_log[k], b_log[k], eg[k]);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    en_mask   = '0;
    burst_limit = '0;
    s_tdata   = '0;
    s_tvalid  = '0;
    s_tlast   = '0;
    m_tready  = 1'b0;
    gate      = '1;
    hs        = '0;
    cfg_limit = '0;
    toggle    = 1'b0;
    perturb   = 1'b0;
    mon_en    = 1'b0;
    prev_busy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      wr_p[i] = 0;
      rd_p[i] = 0;
      seq[i]  = 0;
    end
    test_reset();
    test_round_robin();
    test_burst_limit();
    test_ready_toggle();
    test_en_mask();
    test_reset_mid_packet();
    test_limit_one();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
